// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared CPU definitions used by the ID/EX pipeline register: forwarding
// selects, opcodes, ALU control codes and the carried control-field struct.
package id_ex_pipe_reg_pkg;

  // Forwarding select encodings produced by the hazard detector
  localparam logic [1:0] NO_FWD          = 2'b00;
  localparam logic [1:0] FWD_FROM_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_FROM_MEM_WB = 2'b10;

  // Opcodes the pipeline cares about
  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  // ALU control encodings
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;

  // Fixed-width fields carried from ID to EX. The operand buses live beside
  // this struct in the register because their width is a module parameter.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rw;
    logic [5:0] opcode;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic [1:0] op_a_sel;
    logic [1:0] op_b_sel;
    logic       valid;
  } id_ex_t;

  // True for any load opcode; a bubble opcode must never satisfy this
  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Control fields of an inserted bubble: no writes, ADD, no forwarding
  function automatic id_ex_t bubble_ctrl(input logic [5:0] nop_op);
    id_ex_t b;
    b          = '0;
    b.opcode   = nop_op;
    b.alu_ctrl = ALU_ADD;
    b.op_a_sel = NO_FWD;
    b.op_b_sel = NO_FWD;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module id_ex_pipe_reg_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == {CNT_W{1'b1}});

  // Next count: clear wins, otherwise increment until saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register. Loads decoded ID fields each cycle, inserts a
// bubble on stall or flush, freezes on downstream hold, and counts stall and
// flush events with saturating counters.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 16,
  parameter logic [5:0]  NOP_OPCODE = 6'b000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall_ID,
  input  logic              Flush_ID,
  input  logic              Hold_EX,
  input  logic [4:0]        Rs_ID,
  input  logic [4:0]        Rt_ID,
  input  logic [4:0]        Rw_ID,
  input  logic [5:0]        opcode_ID,
  input  logic [DATA_W-1:0] busA_ID,
  input  logic [DATA_W-1:0] busB_ID,
  input  logic [DATA_W-1:0] imm_ID,
  input  logic              ALU_SRC_ID,
  input  logic [3:0]        ALU_CTRL_ID,
  input  logic              MEM_RD_ID,
  input  logic              MEM_WR_ID,
  input  logic              REG_WR_ID,
  input  logic [1:0]        OP_A_SEL_ID,
  input  logic [1:0]        OP_B_SEL_ID,
  output logic [4:0]        Rs_EX,
  output logic [4:0]        Rt_EX,
  output logic [4:0]        Rw_ID_EX,
  output logic [5:0]        opcode_ID_EX,
  output logic [DATA_W-1:0] busA_EX,
  output logic [DATA_W-1:0] busB_EX,
  output logic [DATA_W-1:0] imm_EX,
  output logic              ALU_SRC_EX,
  output logic [3:0]        ALU_CTRL_EX,
  output logic              MEM_RD_EX,
  output logic              MEM_WR_EX,
  output logic              REG_WR_EX,
  output logic [1:0]        OP_A_SEL_EX,
  output logic [1:0]        OP_B_SEL_EX,
  output logic              VALID_EX,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  id_ex_t            ctrl_q, ctrl_d, ctrl_in;
  logic [DATA_W-1:0] bus_a_q, bus_a_d;
  logic [DATA_W-1:0] bus_b_q, bus_b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              flush_pend_q, flush_pend_d;
  logic              flush_any;
  logic              stall_inc;
  logic              flush_inc;

  // A flush seen during hold is remembered so it still squashes later
  assign flush_any = Flush_ID | flush_pend_q;

  // Flush takes precedence over stall when attributing a bubble
  assign stall_inc = ~Hold_EX & Stall_ID & ~flush_any;
  assign flush_inc = ~Hold_EX & flush_any;

  // Gather the incoming ID fields into the carried struct
  always_comb begin
    ctrl_in          = '0;
    ctrl_in.rs       = Rs_ID;
    ctrl_in.rt       = Rt_ID;
    ctrl_in.rw       = Rw_ID;
    ctrl_in.opcode   = opcode_ID;
    ctrl_in.alu_src  = ALU_SRC_ID;
    ctrl_in.alu_ctrl = ALU_CTRL_ID;
    ctrl_in.mem_rd   = MEM_RD_ID;
    ctrl_in.mem_wr   = MEM_WR_ID;
    ctrl_in.reg_wr   = REG_WR_ID;
    ctrl_in.op_a_sel = OP_A_SEL_ID;
    ctrl_in.op_b_sel = OP_B_SEL_ID;
    ctrl_in.valid    = 1'b1;
  end

  // Next-state selection: hold > bubble > load
  always_comb begin
    ctrl_d       = ctrl_q;
    bus_a_d      = bus_a_q;
    bus_b_d      = bus_b_q;
    imm_d        = imm_q;
    flush_pend_d = flush_pend_q;
    if (Hold_EX) begin
      // Stall is ignored here; the detector re-checks against frozen Rw
      flush_pend_d = flush_pend_q | Flush_ID;
    end else if (flush_any || Stall_ID) begin
      // Zero operands with Rw=0 so forwarding from a bubble yields 0
      ctrl_d       = bubble_ctrl(NOP_OPCODE);
      bus_a_d      = '0;
      bus_b_d      = '0;
      imm_d        = '0;
      flush_pend_d = 1'b0;
    end else begin
      ctrl_d       = ctrl_in;
      bus_a_d      = busA_ID;
      bus_b_d      = busB_ID;
      imm_d        = imm_ID;
      flush_pend_d = 1'b0;
    end
  end

  // Pipeline state with synchronous reset to bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q       <= bubble_ctrl(NOP_OPCODE);
      bus_a_q      <= '0;
      bus_b_q      <= '0;
      imm_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      bus_a_q      <= bus_a_d;
      bus_b_q      <= bus_b_d;
      imm_q        <= imm_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  id_ex_pipe_reg_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clear(reset),
    .inc  (stall_inc),
    .value(stall_cnt)
  );

  id_ex_pipe_reg_sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .clear(reset),
    .inc  (flush_inc),
    .value(flush_cnt)
  );

  assign Rs_EX        = ctrl_q.rs;
  assign Rt_EX        = ctrl_q.rt;
  assign Rw_ID_EX     = ctrl_q.rw;
  assign opcode_ID_EX = ctrl_q.opcode;
  assign busA_EX      = bus_a_q;
  assign busB_EX      = bus_b_q;
  assign imm_EX       = imm_q;
  assign ALU_SRC_EX   = ctrl_q.alu_src;
  assign ALU_CTRL_EX  = ctrl_q.alu_ctrl;
  assign MEM_RD_EX    = ctrl_q.mem_rd;
  assign MEM_WR_EX    = ctrl_q.mem_wr;
  assign REG_WR_EX    = ctrl_q.reg_wr;
  assign OP_A_SEL_EX  = ctrl_q.op_a_sel;
  assign OP_B_SEL_EX  = ctrl_q.op_b_sel;
  assign VALID_EX     = ctrl_q.valid;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus random
// traffic against a behavioural model of the register.
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset, Stall_ID, Flush_ID, Hold_EX;
  logic [4:0]        Rs_ID, Rt_ID, Rw_ID;
  logic [5:0]        opcode_ID;
  logic [DATA_W-1:0] busA_ID, busB_ID, imm_ID;
  logic              ALU_SRC_ID, MEM_RD_ID, MEM_WR_ID, REG_WR_ID;
  logic [3:0]        ALU_CTRL_ID;
  logic [1:0]        OP_A_SEL_ID, OP_B_SEL_ID;
  logic [4:0]        Rs_EX, Rt_EX, Rw_ID_EX;
  logic [5:0]        opcode_ID_EX;
  logic [DATA_W-1:0] busA_EX, busB_EX, imm_EX;
  logic              ALU_SRC_EX, MEM_RD_EX, MEM_WR_EX, REG_WR_EX, VALID_EX;
  logic [3:0]        ALU_CTRL_EX;
  logic [1:0]        OP_A_SEL_EX, OP_B_SEL_EX;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .NOP_OPCODE(6'b000000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Stall_ID    (Stall_ID),
    .Flush_ID    (Flush_ID),
    .Hold_EX     (Hold_EX),
    .Rs_ID       (Rs_ID),
    .Rt_ID       (Rt_ID),
    .Rw_ID       (Rw_ID),
    .opcode_ID   (opcode_ID),
    .busA_ID     (busA_ID),
    .busB_ID     (busB_ID),
    .imm_ID      (imm_ID),
    .ALU_SRC_ID  (ALU_SRC_ID),
    .ALU_CTRL_ID (ALU_CTRL_ID),
    .MEM_RD_ID   (MEM_RD_ID),
    .MEM_WR_ID   (MEM_WR_ID),
    .REG_WR_ID   (REG_WR_ID),
    .OP_A_SEL_ID (OP_A_SEL_ID),
    .OP_B_SEL_ID (OP_B_SEL_ID),
    .Rs_EX       (Rs_EX),
    .Rt_EX       (Rt_EX),
    .Rw_ID_EX    (Rw_ID_EX),
    .opcode_ID_EX(opcode_ID_EX),
    .busA_EX     (busA_EX),
    .busB_EX     (busB_EX),
    .imm_EX      (imm_EX),
    .ALU_SRC_EX  (ALU_SRC_EX),
    .ALU_CTRL_EX (ALU_CTRL_EX),
    .MEM_RD_EX   (MEM_RD_EX),
    .MEM_WR_EX   (MEM_WR_EX),
    .REG_WR_EX   (REG_WR_EX),
    .OP_A_SEL_EX (OP_A_SEL_EX),
    .OP_B_SEL_EX (OP_B_SEL_EX),
    .VALID_EX    (VALID_EX),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  // Reference model: the EX-side view as a flat vector of all outputs
  // (excluding counters), plus pending-flush bit and integer counters.
  localparam int PW = 15 + 6 + 3 * DATA_W + 1 + 4 + 3 + 4 + 1;
  logic [PW-1:0] m_pipe;
  bit            m_pend;
  int            m_stall, m_flush;

  function automatic logic [PW-1:0] id_vec();
    return {Rs_ID, Rt_ID, Rw_ID, opcode_ID, busA_ID, busB_ID, imm_ID, ALU_SRC_ID,
            ALU_CTRL_ID, MEM_RD_ID, MEM_WR_ID, REG_WR_ID, OP_A_SEL_ID, OP_B_SEL_ID, 1'b1};
  endfunction

  function automatic logic [PW-1:0] ex_vec();
    return {Rs_EX, Rt_EX, Rw_ID_EX, opcode_ID_EX, busA_EX, busB_EX, imm_EX, ALU_SRC_EX,
            ALU_CTRL_EX, MEM_RD_EX, MEM_WR_EX, REG_WR_EX, OP_A_SEL_EX, OP_B_SEL_EX, VALID_EX};
  endfunction

  // Bubble is all-zero because the NOP opcode is 6'b000000
  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_edge();
    bit fl;
    if (reset) begin
      m_pipe = '0; m_pend = 0; m_stall = 0; m_flush = 0;
    end else if (Hold_EX) begin
      if (Flush_ID) m_pend = 1;
    end else begin
      fl = Flush_ID || m_pend;
      if (fl) m_flush = sat(m_flush + 1);
      else if (Stall_ID) m_stall = sat(m_stall + 1);
      m_pipe = (fl || Stall_ID) ? '0 : id_vec();
      m_pend = 0;
    end
  endtask

  // One clock: inputs already set at the negedge; sample at next negedge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_id();
    Rs_ID       = 5'($urandom);
    Rt_ID       = 5'($urandom);
    Rw_ID       = 5'($urandom_range(1, 31));
    opcode_ID   = 6'($urandom_range(1, 63));
    busA_ID     = $urandom;
    busB_ID     = $urandom;
    imm_ID      = $urandom;
    ALU_SRC_ID  = 1'($urandom);
    ALU_CTRL_ID = 4'($urandom);
    MEM_RD_ID   = 1'($urandom);
    MEM_WR_ID   = 1'($urandom);
    REG_WR_ID   = 1'b1;
    OP_A_SEL_ID = 2'($urandom_range(1, 2));
    OP_B_SEL_ID = 2'($urandom_range(0, 2));
  endtask

  task automatic ctl(input logic r, input logic s, input logic f, input logic h);
    reset = r; Stall_ID = s; Flush_ID = f; Hold_EX = h;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rand_id();
      ctl(1, 1, 1, 1);
      tick();
      checks++;
      if (ex_vec() !== '0 || VALID_EX !== 1'b0 || opcode_ID_EX !== 6'b000000) begin
        errors++;
        $display("FAIL reset_outputs: got %h want all-zero bubble", ex_vec());
      end
      checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
        errors++;
        $display("FAIL reset_counters: got stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt);
      end
    end
  endtask

  task automatic test_load_add();
    ctl(0, 0, 0, 0);
    rand_id();
    Rw_ID = 5'd5; busA_ID = 32'h10; busB_ID = 32'h20; REG_WR_ID = 1'b1;
    OP_A_SEL_ID = 2'b01;
    tick();
    checks++;
    if (Rw_ID_EX !== 5'd5 || busA_EX !== 32'h10 || busB_EX !== 32'h20 ||
        OP_A_SEL_EX !== 2'b01 || VALID_EX !== 1'b1 || REG_WR_EX !== 1'b1) begin
      errors++;
      $display("FAIL load_add: got rw=%0d a=%h b=%h sel=%b v=%b want 5/10/20/01/1",
               Rw_ID_EX, busA_EX, busB_EX, OP_A_SEL_EX, VALID_EX);
    end
    checks++;
    if (ex_vec() !== m_pipe) begin
      errors++;
      $display("FAIL load_add_full: got %h want %h", ex_vec(), m_pipe);
    end
  endtask

  task automatic test_load_use();
    int s0;
    s0 = m_stall;
    rand_id();
    Rw_ID = 5'd7;
    ctl(0, 1, 0, 0);
    tick();
    checks++;
    if (Rw_ID_EX !== 5'd0 || REG_WR_EX !== 1'b0 || VALID_EX !== 1'b0 ||
        ex_vec() !== '0 || int'(stall_cnt) != s0 + 1) begin
      errors++;
      $display("FAIL load_use_bubble: got rw=%0d wr=%b v=%b stall=%0d want 0/0/0/%0d",
               Rw_ID_EX, REG_WR_EX, VALID_EX, stall_cnt, s0 + 1);
    end
    ctl(0, 0, 0, 0);
    tick();
    checks++;
    if (ex_vec() !== m_pipe || VALID_EX !== 1'b1 || Rw_ID_EX !== 5'd7) begin
      errors++;
      $display("FAIL load_use_resume: got %h want %h", ex_vec(), m_pipe);
    end
  endtask

  task automatic test_hold_flush();
    logic [PW-1:0] frozen;
    ctl(1, 0, 0, 0);
    tick();
    ctl(0, 0, 0, 0);
    rand_id();
    tick();
    frozen = ex_vec();
    for (int c = 1; c <= 3; c++) begin
      rand_id();
      ctl(0, (c == 3), (c == 2), 1);
      tick();
      checks++;
      if (ex_vec() !== frozen || ex_vec() !== m_pipe || flush_cnt !== '0 ||
          stall_cnt !== '0) begin
        errors++;
        $display("FAIL hold_frozen_c%0d: got %h flush=%0d want %h flush=0",
                 c, ex_vec(), flush_cnt, frozen);
      end
    end
    rand_id();
    ctl(0, 0, 0, 0);
    tick();
    checks++;
    if (ex_vec() !== '0 || flush_cnt !== 4'd1 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL hold_release_bubble: got %h flush=%0d want 0 flush=1", ex_vec(), flush_cnt);
    end
    rand_id();
    tick();
    checks++;
    if (ex_vec() !== m_pipe || VALID_EX !== 1'b1 || flush_cnt !== 4'd1) begin
      errors++;
      $display("FAIL hold_pend_cleared: got v=%b flush=%0d want v=1 flush=1", VALID_EX, flush_cnt);
    end
  endtask

  task automatic test_stall_flush();
    ctl(1, 0, 0, 0);
    tick();
    rand_id();
    ctl(0, 1, 1, 0);
    tick();
    checks++;
    if (ex_vec() !== '0 || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stall_flush: got %h stall=%0d flush=%0d want 0 stall=0 flush=1",
               ex_vec(), stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    ctl(1, 0, 0, 0);
    tick();
    for (int i = 1; i <= 20; i++) begin
      rand_id();
      ctl(0, 1, 0, 0);
      tick();
      checks++;
      if (int'(stall_cnt) != ((i > CMAX) ? CMAX : i) || int'(stall_cnt) != m_stall) begin
        errors++;
        $display("FAIL sat_step%0d: got %0d want %0d", i, stall_cnt, (i > CMAX) ? CMAX : i);
      end
    end
    checks++;
    if (stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_final: got %h want f", stall_cnt);
    end
    ctl(1, 1, 0, 0);
    tick();
    checks++;
    if (stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL sat_reset: got %h want 0", stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_id();
      ctl($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25,
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25);
      tick();
      checks++;
      if (ex_vec() !== m_pipe || int'(stall_cnt) != m_stall || int'(flush_cnt) != m_flush) begin
        errors++;
        $display("FAIL random_%0d: got %h s=%0d f=%0d want %h s=%0d f=%0d",
                 i, ex_vec(), stall_cnt, flush_cnt, m_pipe, m_stall, m_flush);
      end
    end
  endtask

  initial begin
    m_pipe = '0; m_pend = 0; m_stall = 0; m_flush = 0;
    ctl(1, 0, 0, 0);
    rand_id();
    @(negedge clk);
    test_reset();
    test_load_add();
    test_load_use();
    test_hold_flush();
    test_stall_flush();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
